// File: rtl/spi_slave_rx.sv
// SPI mode-0 slave receiver: synchronises ss/sclk/mosi, deserialises bytes into a
// first-word-fall-through FIFO and shifts a host-loaded response byte out on MISO.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | ss high (or not yet re-armed after reset); miso held low
// ST_SHIFT | frame open; sclk rises sample mosi, falls advance miso
module spi_slave_rx #(
   parameter int FIFO_DEPTH  = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_ss,
   input  logic       i_sclk,
   input  logic       i_mosi,
   output logic       o_miso,
   output logic [7:0] o_rx_data,
   output logic       o_rx_valid,
   input  logic       i_rx_ready,
   output logic       o_rx_overflow,
   input  logic       i_ovf_clr,
   input  logic [7:0] i_tx_data,
   input  logic       i_tx_load,
   output logic       o_frame_active,
   output logic [7:0] o_byte_count,
   output logic       o_frame_done
);

   localparam int         AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

   typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

   state_t r_state, w_state_nxt;

   logic [SYNC_STAGES-1:0] r_ss_sync, r_sclk_sync, r_mosi_sync, r_vld;
   logic r_ss_d, r_sclk_d, r_armed;
   logic w_ss_s, w_sclk_s, w_mosi_s;
   logic w_ss_fall, w_ss_rise, w_sclk_rise, w_sclk_fall;
   logic w_start, w_stop, w_rx_bit, w_tx_bit;

   logic [7:0] r_tx_reg, r_shift_tx, r_shift_rx, r_byte_count;
   logic [2:0] r_bit_cnt;
   logic       r_miso, r_reload, r_byte_done, r_frame_done;

   logic [7:0]  r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wptr, r_rptr;
   logic [AW:0]   r_count;
   logic        r_overflow;
   logic        w_push, w_pop, w_full, w_wr, w_drop;

   assign w_ss_s   = r_ss_sync[SYNC_STAGES-1];
   assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];
   assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];

   // r_vld marks when the chain holds real pin values; a frame may only start after
   // ss has been seen high post-reset, so a reset taken mid-frame cannot resume it.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_ss_sync   <= '1;
         r_sclk_sync <= '0;
         r_mosi_sync <= '0;
         r_vld       <= '0;
         r_ss_d      <= 1'b1;
         r_sclk_d    <= 1'b0;
         r_armed     <= 1'b0;
      end else begin
         r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], i_ss};
         r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_sclk};
         r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
         r_vld       <= {r_vld[SYNC_STAGES-2:0], 1'b1};
         r_ss_d      <= w_ss_s;
         r_sclk_d    <= w_sclk_s;
         r_armed     <= r_armed | (r_vld[SYNC_STAGES-1] & w_ss_s);
      end
   end

   assign w_ss_fall   = r_armed & r_ss_d & ~w_ss_s;
   assign w_ss_rise   = ~r_ss_d & w_ss_s;
   assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
   assign w_sclk_fall = ~w_sclk_s & r_sclk_d;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_stop      = 1'b0;
      w_rx_bit    = 1'b0;
      w_tx_bit    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_ss_fall) begin
               w_state_nxt = ST_SHIFT;
               w_start     = 1'b1;
            end
         end
         ST_SHIFT: begin
            if (w_ss_rise) begin
               w_state_nxt = ST_IDLE;
               w_stop      = 1'b1;
            end else begin
               w_rx_bit = w_sclk_rise;
               w_tx_bit = w_sclk_fall;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_tx_reg     <= '0;
         r_shift_tx   <= '0;
         r_shift_rx   <= '0;
         r_bit_cnt    <= '0;
         r_byte_count <= '0;
         r_miso       <= 1'b0;
         r_reload     <= 1'b0;
         r_byte_done  <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         if (i_tx_load) r_tx_reg <= i_tx_data;
         r_byte_done  <= 1'b0;
         r_frame_done <= w_stop;
         if (w_start) begin
            r_bit_cnt  <= '0;
            r_shift_tx <= r_tx_reg;
            r_miso     <= r_tx_reg[7];
            r_reload   <= 1'b0;
         end else if (w_stop) begin
            r_bit_cnt <= '0;
            r_miso    <= 1'b0;
            r_reload  <= 1'b0;
         end else begin
            if (w_rx_bit) begin
               r_shift_rx <= {r_shift_rx[6:0], w_mosi_s};
               r_bit_cnt  <= r_bit_cnt + 3'd1;
               if (r_bit_cnt == 3'd7) begin
                  r_byte_done <= 1'b1;
                  r_reload    <= 1'b1;
               end
            end
            // The fall after a completed byte picks up whatever tx_load left in tx_reg.
            if (w_tx_bit) begin
               if (r_reload) begin
                  r_shift_tx <= r_tx_reg;
                  r_miso     <= r_tx_reg[7];
                  r_reload   <= 1'b0;
               end else begin
                  r_shift_tx <= {r_shift_tx[6:0], 1'b0};
                  r_miso     <= r_shift_tx[6];
               end
            end
         end
         if (w_start)
            r_byte_count <= '0;
         else if (r_byte_done && (r_byte_count != 8'hFF))
            r_byte_count <= r_byte_count + 8'd1;
      end
   end

   assign w_push = r_byte_done;
   assign w_pop  = o_rx_valid & i_rx_ready;
   assign w_full = (r_count == DEPTH_C);
   assign w_wr   = w_push & (~w_full | w_pop);
   assign w_drop = w_push & w_full & ~w_pop;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_wr) begin
            r_mem[r_wptr] <= r_shift_rx;
            r_wptr        <= r_wptr + AW'(1);
         end
         if (w_pop) r_rptr <= r_rptr + AW'(1);
         if (w_wr && !w_pop)
            r_count <= r_count + (AW+1)'(1);
         else if (!w_wr && w_pop)
            r_count <= r_count - (AW+1)'(1);
         if (w_drop)         r_overflow <= 1'b1;
         else if (i_ovf_clr) r_overflow <= 1'b0;
      end
   end

   assign o_miso         = r_miso;
   assign o_rx_data      = r_mem[r_rptr];
   assign o_rx_valid     = (r_count != '0);
   assign o_rx_overflow  = r_overflow;
   assign o_frame_active = (r_state == ST_SHIFT);
   assign o_byte_count   = r_byte_count;
   assign o_frame_done   = r_frame_done;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Bench for spi_slave_rx: bit-banged SPI master with randomized bytes, checked against
// a queue model of the receive FIFO, overflow flag and per-frame byte count.
module tb_spi_slave_rx;

   localparam int FIFO_DEPTH  = 4;
   localparam int SYNC_STAGES = 2;
   localparam int HALF        = 6;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ss = 1'b1, sclk = 1'b0, mosi = 1'b0;
   logic       rx_ready = 1'b0, ovf_clr = 1'b0, tx_load = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       o_miso, o_rx_valid, o_rx_overflow, o_frame_active, o_frame_done;
   logic [7:0] o_rx_data, o_byte_count;

   spi_slave_rx #(.FIFO_DEPTH(FIFO_DEPTH), .SYNC_STAGES(SYNC_STAGES)) dut (
      .i_clk(clk), .i_rst(rst), .i_ss(ss), .i_sclk(sclk), .i_mosi(mosi),
      .o_miso(o_miso), .o_rx_data(o_rx_data), .o_rx_valid(o_rx_valid),
      .i_rx_ready(rx_ready), .o_rx_overflow(o_rx_overflow), .i_ovf_clr(ovf_clr),
      .i_tx_data(tx_data), .i_tx_load(tx_load), .o_frame_active(o_frame_active),
      .o_byte_count(o_byte_count), .o_frame_done(o_frame_done)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   logic [7:0] m_q[$];
   bit         m_ovf = 1'b0;
   int         m_bcnt = 0;
   logic [7:0] got[$];
   bit         collect = 1'b0;
   logic [7:0] pop_seen;

   always @(negedge clk)
      if (collect && o_rx_valid && rx_ready) got.push_back(o_rx_data);

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic model_push(input logic [7:0] b);
      if (m_q.size() < FIFO_DEPTH) m_q.push_back(b);
      else                         m_ovf = 1'b1;
      if (m_bcnt < 255) m_bcnt++;
   endtask

   task automatic ss_fall();
      ss = 1'b0;
      m_bcnt = 0;
      wait_clks(8);
   endtask

   task automatic ss_rise(output int pulses);
      wait_clks(4);
      ss = 1'b1;
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (o_frame_done) pulses++;
      end
   endtask

   // hook 1: one-cycle rx_ready on the push cycle; hook 2: one-cycle ovf_clr on it.
   // The push lands SYNC_STAGES+1 cycles after sclk is raised on the 8th bit.
   task automatic spi_xfer(input logic [7:0] mo, input int nbits, input int load_bit,
                           input logic [7:0] load_val, input int hook, output logic [7:0] mi);
      mi = 8'h00;
      for (int i = 0; i < nbits; i++) begin
         mosi = mo[7-i];
         if (i == load_bit) begin
            tx_data = load_val;
            tx_load = 1'b1;
            @(negedge clk);
            tx_load = 1'b0;
            wait_clks(HALF-1);
         end else begin
            wait_clks(HALF);
         end
         mi[7-i] = o_miso;
         sclk = 1'b1;
         if (hook != 0 && i == 7) begin
            wait_clks(SYNC_STAGES+1);
            pop_seen = o_rx_data;
            if (hook == 1) rx_ready = 1'b1;
            else           ovf_clr  = 1'b1;
            @(negedge clk);
            rx_ready = 1'b0;
            ovf_clr  = 1'b0;
            wait_clks(HALF-SYNC_STAGES-2);
         end else begin
            wait_clks(HALF);
         end
         sclk = 1'b0;
      end
   endtask

   task automatic test_reset();
      wait_clks($urandom_range(3, 12));
      rst = 1'b0;
      wait_clks($urandom_range(5, 20));
      #($urandom_range(1, 4));
      rst = 1'b1;
      #1;
      n_cmp++; if (o_miso !== 1'b0)         begin n_err++; $display("FAIL reset_miso got=%b exp=0", o_miso); end
      n_cmp++; if (o_rx_valid !== 1'b0)     begin n_err++; $display("FAIL reset_rx_valid got=%b exp=0", o_rx_valid); end
      n_cmp++; if (o_rx_data !== 8'h00)     begin n_err++; $display("FAIL reset_rx_data got=%h exp=00", o_rx_data); end
      n_cmp++; if (o_rx_overflow !== 1'b0)  begin n_err++; $display("FAIL reset_overflow got=%b exp=0", o_rx_overflow); end
      n_cmp++; if (o_frame_active !== 1'b0) begin n_err++; $display("FAIL reset_frame_active got=%b exp=0", o_frame_active); end
      n_cmp++; if (o_byte_count !== 8'h00)  begin n_err++; $display("FAIL reset_byte_count got=%h exp=00", o_byte_count); end
      n_cmp++; if (o_frame_done !== 1'b0)   begin n_err++; $display("FAIL reset_frame_done got=%b exp=0", o_frame_done); end
      @(negedge clk);
      rst = 1'b0;
      wait_clks(10);
      n_cmp++; if (o_miso !== 1'b0) begin n_err++; $display("FAIL idle_miso got=%b exp=0", o_miso); end
   endtask

   task automatic test_single_byte();
      logic [7:0] mi;
      int p;
      ss_fall();
      n_cmp++; if (o_frame_active !== 1'b1) begin n_err++; $display("FAIL single_frame_active got=%b exp=1", o_frame_active); end
      spi_xfer(8'hA5, 8, -1, 8'h00, 0, mi);
      model_push(8'hA5);
      ss_rise(p);
      n_cmp++; if (p !== 1)                  begin n_err++; $display("FAIL single_frame_done pulses=%0d exp=1", p); end
      n_cmp++; if (o_rx_valid !== 1'b1)      begin n_err++; $display("FAIL single_rx_valid got=%b exp=1", o_rx_valid); end
      n_cmp++; if (o_rx_data !== m_q[0])     begin n_err++; $display("FAIL single_rx_data got=%h exp=%h", o_rx_data, m_q[0]); end
      n_cmp++; if (o_byte_count !== 8'(m_bcnt)) begin n_err++; $display("FAIL single_byte_count got=%0d exp=%0d", o_byte_count, m_bcnt); end
      n_cmp++; if (o_frame_active !== 1'b0)  begin n_err++; $display("FAIL single_frame_inactive got=%b exp=0", o_frame_active); end
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
      void'(m_q.pop_front());
      @(negedge clk);
      n_cmp++; if (o_rx_valid !== (m_q.size() != 0)) begin n_err++; $display("FAIL single_after_pop got=%b exp=%b", o_rx_valid, m_q.size() != 0); end
   endtask

   task automatic test_long_frame();
      logic [7:0] sent[$];
      logic [7:0] mi;
      int p;
      sent = '{8'h1B, 8'h5B, 8'h6A};
      for (int i = 0; i < 14; i++) sent.push_back(8'($urandom));
      sent.push_back(8'h41);
      sent.push_back(8'h42);
      got.delete();
      rx_ready = 1'b1;
      collect  = 1'b1;
      ss_fall();
      foreach (sent[i]) spi_xfer(sent[i], 8, -1, 8'h00, 0, mi);
      ss_rise(p);
      collect  = 1'b0;
      rx_ready = 1'b0;
      n_cmp++; if (got.size() !== sent.size()) begin n_err++; $display("FAIL long_count got=%0d exp=%0d", got.size(), sent.size()); end
      for (int i = 0; i < sent.size() && i < got.size(); i++) begin
         n_cmp++; if (got[i] !== sent[i]) begin n_err++; $display("FAIL long_byte[%0d] got=%h exp=%h", i, got[i], sent[i]); end
      end
      n_cmp++; if (o_byte_count !== 8'd19)  begin n_err++; $display("FAIL long_byte_count got=%0d exp=19", o_byte_count); end
      n_cmp++; if (o_rx_overflow !== 1'b0)  begin n_err++; $display("FAIL long_overflow got=%b exp=0", o_rx_overflow); end
      n_cmp++; if (o_rx_valid !== 1'b0)     begin n_err++; $display("FAIL long_drained got=%b exp=0", o_rx_valid); end
      n_cmp++; if (p !== 1)                 begin n_err++; $display("FAIL long_frame_done pulses=%0d exp=1", p); end
   endtask

   task automatic test_overflow();
      logic [7:0] mi, head;
      int p;
      ss_fall();
      for (int b = 1; b <= 6; b++) begin
         spi_xfer(8'(b), 8, -1, 8'h00, 0, mi);
         model_push(8'(b));
      end
      ss_rise(p);
      n_cmp++; if (o_rx_overflow !== m_ovf)  begin n_err++; $display("FAIL ovf_set got=%b exp=%b", o_rx_overflow, m_ovf); end
      n_cmp++; if (o_byte_count !== 8'(m_bcnt)) begin n_err++; $display("FAIL ovf_byte_count got=%0d exp=%0d", o_byte_count, m_bcnt); end
      ovf_clr = 1'b1;
      @(negedge clk);
      ovf_clr = 1'b0;
      m_ovf = 1'b0;
      @(negedge clk);
      n_cmp++; if (o_rx_overflow !== m_ovf) begin n_err++; $display("FAIL ovf_clear got=%b exp=%b", o_rx_overflow, m_ovf); end
      ss_fall();
      head = m_q[0];
      spi_xfer(8'h07, 8, -1, 8'h00, 1, mi);
      void'(m_q.pop_front());
      model_push(8'h07);
      wait_clks(2);
      n_cmp++; if (pop_seen !== head)        begin n_err++; $display("FAIL full_pushpop_head got=%h exp=%h", pop_seen, head); end
      n_cmp++; if (o_rx_overflow !== m_ovf)  begin n_err++; $display("FAIL full_pushpop_ovf got=%b exp=%b", o_rx_overflow, m_ovf); end
      spi_xfer(8'h08, 8, -1, 8'h00, 2, mi);
      model_push(8'h08);
      wait_clks(2);
      n_cmp++; if (o_rx_overflow !== m_ovf)  begin n_err++; $display("FAIL ovf_beats_clr got=%b exp=%b", o_rx_overflow, m_ovf); end
      ss_rise(p);
      while (m_q.size() > 0) begin
         n_cmp++; if (o_rx_valid !== 1'b1 || o_rx_data !== m_q[0]) begin n_err++; $display("FAIL ovf_drain got=%b/%h exp=1/%h", o_rx_valid, o_rx_data, m_q[0]); end
         rx_ready = 1'b1;
         @(negedge clk);
         rx_ready = 1'b0;
         void'(m_q.pop_front());
      end
      n_cmp++; if (o_rx_valid !== 1'b0) begin n_err++; $display("FAIL ovf_empty got=%b exp=0", o_rx_valid); end
      ovf_clr = 1'b1;
      @(negedge clk);
      ovf_clr = 1'b0;
      m_ovf = 1'b0;
   endtask

   task automatic test_partial_byte();
      logic [7:0] mi, b;
      int p, nb;
      ss_fall();
      for (int i = 0; i < 2; i++) begin
         b = 8'($urandom);
         spi_xfer(b, 8, -1, 8'h00, 0, mi);
         model_push(b);
      end
      nb = $urandom_range(1, 7);
      spi_xfer(8'($urandom), nb, -1, 8'h00, 0, mi);
      ss_rise(p);
      n_cmp++; if (p !== 1) begin n_err++; $display("FAIL partial_frame_done pulses=%0d exp=1", p); end
      n_cmp++; if (o_byte_count !== 8'(m_bcnt)) begin n_err++; $display("FAIL partial_byte_count got=%0d exp=%0d", o_byte_count, m_bcnt); end
      while (m_q.size() > 0) begin
         n_cmp++; if (o_rx_valid !== 1'b1 || o_rx_data !== m_q[0]) begin n_err++; $display("FAIL partial_drain got=%b/%h exp=1/%h", o_rx_valid, o_rx_data, m_q[0]); end
         rx_ready = 1'b1;
         @(negedge clk);
         rx_ready = 1'b0;
         void'(m_q.pop_front());
      end
      n_cmp++; if (o_rx_valid !== 1'b0) begin n_err++; $display("FAIL partial_no_push got=%b exp=0", o_rx_valid); end
   endtask

   task automatic test_miso_response();
      logic [7:0] mi1, mi2, mi3;
      int p;
      rx_ready = 1'b1;
      tx_data = 8'h3C;
      tx_load = 1'b1;
      @(negedge clk);
      tx_load = 1'b0;
      ss_fall();
      spi_xfer(8'($urandom), 8, 4, 8'hC3, 0, mi1);
      spi_xfer(8'($urandom), 8, -1, 8'h00, 0, mi2);
      spi_xfer(8'($urandom), 8, -1, 8'h00, 0, mi3);
      ss_rise(p);
      rx_ready = 1'b0;
      n_cmp++; if (mi1 !== 8'h3C) begin n_err++; $display("FAIL miso_first got=%h exp=3c", mi1); end
      n_cmp++; if (mi2 !== 8'hC3) begin n_err++; $display("FAIL miso_second got=%h exp=c3", mi2); end
      n_cmp++; if (mi3 !== 8'hC3) begin n_err++; $display("FAIL miso_third got=%h exp=c3", mi3); end
      n_cmp++; if (o_miso !== 1'b0) begin n_err++; $display("FAIL miso_idle got=%b exp=0", o_miso); end
   endtask

   task automatic test_reset_mid_byte();
      logic [7:0] mi, b;
      int p;
      ss_fall();
      spi_xfer(8'($urandom), 8, -1, 8'h00, 0, mi);
      spi_xfer(8'hFF, 4, -1, 8'h00, 0, mi);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      m_q.delete();
      m_ovf = 1'b0;
      n_cmp++; if (o_miso !== 1'b0)         begin n_err++; $display("FAIL rstmid_miso got=%b exp=0", o_miso); end
      n_cmp++; if (o_rx_valid !== 1'b0)     begin n_err++; $display("FAIL rstmid_rx_valid got=%b exp=0", o_rx_valid); end
      n_cmp++; if (o_frame_active !== 1'b0) begin n_err++; $display("FAIL rstmid_frame_active got=%b exp=0", o_frame_active); end
      @(negedge clk);
      rst = 1'b0;
      spi_xfer(8'($urandom), 8, -1, 8'h00, 0, mi);
      spi_xfer(8'($urandom), 8, -1, 8'h00, 0, mi);
      n_cmp++; if (o_frame_active !== 1'b0) begin n_err++; $display("FAIL rstmid_no_restart got=%b exp=0", o_frame_active); end
      ss_rise(p);
      n_cmp++; if (o_rx_valid !== 1'b0)    begin n_err++; $display("FAIL rstmid_no_push got=%b exp=0", o_rx_valid); end
      n_cmp++; if (o_byte_count !== 8'h00) begin n_err++; $display("FAIL rstmid_byte_count got=%0d exp=0", o_byte_count); end
      b = 8'($urandom);
      ss_fall();
      spi_xfer(b, 8, -1, 8'h00, 0, mi);
      model_push(b);
      ss_rise(p);
      n_cmp++; if (o_rx_valid !== 1'b1 || o_rx_data !== m_q[0]) begin n_err++; $display("FAIL rstmid_fresh got=%b/%h exp=1/%h", o_rx_valid, o_rx_data, m_q[0]); end
      n_cmp++; if (o_byte_count !== 8'(m_bcnt)) begin n_err++; $display("FAIL rstmid_fresh_count got=%0d exp=%0d", o_byte_count, m_bcnt); end
   endtask

   initial begin
      test_reset();
      test_single_byte();
      test_long_frame();
      test_overflow();
      test_partial_byte();
      test_miso_response();
      test_reset_mid_byte();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
